sat_addsub_pipe: RTL and testbench

- Parametrised, pipelined, carry-lookahead signed adder/subtractor with selectable saturating or wrapping result and valid/ready handshakes on input and output.
- Generalises the fixed-width combinational saturating adder: any WIDTH that is a multiple of 4, a 1- or 2-stage pipeline, and raw carry-out alongside the overflow flag.
- Overflow detection is correct for subtraction.
- Sits between the ID/EX operand registers and the EX-stage result mux. Serves ADD/SUB/address arithmetic when the core is built with a wider datapath or a deeper EX stage.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/sat_addsub_pipe_cla_group.sv | 32 +++
 rtl/sat_addsub_pipe.sv | 199 +++++++++++++++++++
 tb/tb_sat_addsub_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and constant helpers for the saturating add/sub datapath.
// Provides the CLA group width, the pipeline split point and saturation limits.
package alu_pkg;

  localparam int GRP_W = 4;
  localparam int MAX_W = 256;

  // Low-half width for a two-stage split, rounded down to whole CLA groups.
  function automatic int split_point(input int width);
    return ((width / 2) / GRP_W) * GRP_W;
  endfunction

  function automatic logic [MAX_W-1:0] SAT_POS(input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] SAT_NEG(input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    r[width-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sat_addsub_pipe_cla_group.sv
// cla_group: 4-bit carry-lookahead adder slice exporting group propagate/generate.
// Group P/G depend only on the operands, never on cin.
module cla_group
  import alu_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             p,
  output logic             g
);

  logic [GRP_W-1:0] pb;
  logic [GRP_W-1:0] gb;
  logic [GRP_W-1:0] c;

  assign pb = a ^ b;
  assign gb = a & b;

  assign c[0] = cin;
  assign c[1] = gb[0] | (pb[0] & cin);
  assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
  assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
              | (pb[2] & pb[1] & pb[0] & cin);

  assign s = pb ^ c;
  assign p = &pb;
  assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
           | (pb[3] & pb[2] & pb[1] & gb[0]);

endmodule

// File: rtl/sat_addsub_pipe.sv
// Pipelined CLA signed add/sub with saturate-or-wrap, valid/ready on both sides.
// Optional overflow event counter built when SAT_ADDSUB_OVF_CNT_EN is defined.
module sat_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             cout,
  input  logic             cnt_clr,
  output logic [15:0]      ovf_cnt
);

  localparam int NG    = WIDTH / GRP_W;
  localparam int SPLIT = split_point(WIDTH);
  localparam int NLO   = SPLIT / GRP_W;
  localparam logic [WIDTH-1:0] SAT_P = WIDTH'(SAT_POS(WIDTH));
  localparam logic [WIDTH-1:0] SAT_N = WIDTH'(SAT_NEG(WIDTH));

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;
  logic             cout_q;
  logic             advance;

  logic [WIDTH-1:0] grp_a, grp_b, grp_s;
  logic [NG-1:0]    grp_p, grp_g, grp_cin;

  // Operands as seen by the final stage, whichever pipeline depth is built.
  logic             fin_valid;
  logic [WIDTH-1:0] fin_raw;
  logic             fin_cout;
  logic             fin_a_msb;
  logic             fin_b_msb;
  logic             fin_sat;

  assign advance  = !out_valid_q | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group u_grp (
      .a   (grp_a[k*GRP_W +: GRP_W]),
      .b   (grp_b[k*GRP_W +: GRP_W]),
      .cin (grp_cin[k]),
      .s   (grp_s[k*GRP_W +: GRP_W]),
      .p   (grp_p[k]),
      .g   (grp_g[k])
    );
  end

  if (STAGES == 1) begin : g_one
    logic [WIDTH-1:0] beff;
    assign beff  = sub ? ~b : b;
    assign grp_a = a;
    assign grp_b = beff;

    always_comb begin
      logic c;
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      grp_cin = '0;
      c       = sub;
      for (int k = 0; k < NG; k++) begin
        grp_cin[k] = c;
        c          = grp_g[k] | (grp_p[k] & c);
      end
      fin_cout = c;
    end

    assign fin_valid = in_valid;
    assign fin_raw   = grp_s;
    assign fin_a_msb = a[WIDTH-1];
    assign fin_b_msb = beff[WIDTH-1];
    assign fin_sat   = sat;
  end else begin : g_two
    logic                   s1_valid_q;
    logic [SPLIT-1:0]       s1_lo_q;
    logic                   s1_c_q;
    logic [WIDTH-SPLIT-1:0] s1_a_hi_q;
    logic [WIDTH-SPLIT-1:0] s1_b_hi_q;
    logic                   s1_sub_q;
    logic                   s1_sat_q;
    logic                   lo_cout;

    // Low groups take live operands; high groups take the stage-1 registers.
    assign grp_a = {s1_a_hi_q, a[SPLIT-1:0]};
    assign grp_b = {(s1_sub_q ? ~s1_b_hi_q : s1_b_hi_q),
                    (sub ? ~b[SPLIT-1:0] : b[SPLIT-1:0])};

    always_comb begin
      logic c;
      grp_cin = '0;
      c       = sub;
      for (int k = 0; k < NLO; k++) begin
        grp_cin[k] = c;
        c          = grp_g[k] | (grp_p[k] & c);
      end
      lo_cout = c;
      c       = s1_c_q;
      for (int k = NLO; k < NG; k++) begin
        grp_cin[k] = c;
        c          = grp_g[k] | (grp_p[k] & c);
      end
      fin_cout = c;
    end

    // NOTE: datapath registers are reset too, so the outputs read 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_lo_q    <= '0;
        s1_c_q     <= 1'b0;
        s1_a_hi_q  <= '0;
        s1_b_hi_q  <= '0;
        s1_sub_q   <= 1'b0;
        s1_sat_q   <= 1'b0;
      end else if (advance) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_lo_q   <= grp_s[SPLIT-1:0];
          s1_c_q    <= lo_cout;
          s1_a_hi_q <= a[WIDTH-1:SPLIT];
          s1_b_hi_q <= b[WIDTH-1:SPLIT];
          s1_sub_q  <= sub;
          s1_sat_q  <= sat;
        end
      end
    end

    assign fin_valid = s1_valid_q;
    assign fin_raw   = {grp_s[WIDTH-1:SPLIT], s1_lo_q};
    assign fin_a_msb = s1_a_hi_q[WIDTH-SPLIT-1];
    assign fin_b_msb = s1_b_hi_q[WIDTH-SPLIT-1] ^ s1_sub_q;
    assign fin_sat   = s1_sat_q;
  end

  logic             ovf_d;
  logic [WIDTH-1:0] sum_d;

  assign ovf_d = (fin_a_msb == fin_b_msb) & (fin_raw[WIDTH-1] != fin_a_msb);
  assign sum_d = (fin_sat & ovf_d) ? (fin_a_msb ? SAT_N : SAT_P) : fin_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
    end else if (advance) begin
      out_valid_q <= fin_valid;
      if (fin_valid) begin
        sum_q  <= sum_d;
        ovf_q  <= ovf_d;
        cout_q <= fin_cout;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;
  assign cout      = cout_q;

`ifdef SAT_ADDSUB_OVF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Clear takes priority over a coincident overflow handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (out_valid_q && out_ready && ovf_q && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign ovf_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign ovf_cnt        = '0;
`endif

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Scoreboard bench for sat_addsub_pipe: stimulus pushes expected results,
// an independent monitor pops and compares on every output handshake.
module tb_sat_addsub_pipe;

  localparam int W = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         sub, sat;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         ovf, cout;
  logic         cnt_clr;
  logic [15:0]  ovf_cnt;

  always #5 clk = ~clk;

  sat_addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf),
    .cout      (cout),
    .cnt_clr   (cnt_clr),
    .ovf_cnt   (ovf_cnt)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
    logic         cout;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   cyc        = 0;
  int   last_lat   = -1;
  int   n_results  = 0;
  int   n_expected = 0;
  bit   rand_ready = 1'b0;

`ifdef SAT_ADDSUB_OVF_CNT_EN
  localparam int CNT_AFTER_3 = 3;
`else
  localparam int CNT_AFTER_3 = 0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then range check for overflow.
  function automatic exp_t model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                 input logic sub_v, input logic sat_v);
    exp_t       e;
    int         sa, sbv, exact;
    logic [W:0] usum;
    sa     = int'($signed(a_v));
    sbv    = int'($signed(b_v));
    exact  = sub_v ? (sa - sbv) : (sa + sbv);
    e.ovf  = (exact > (2**(W-1)) - 1) || (exact < -(2**(W-1)));
    usum   = {1'b0, a_v} + {1'b0, b_v};
    e.cout = sub_v ? (a_v >= b_v) : usum[W];
    if (e.ovf && sat_v) e.sum = (exact < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                e.sum = W'(exact);
    e.acc  = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got sum %0h, expected no result", sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("ovf", ovf, e.ovf);
        check("cout", cout, e.cout);
        last_lat = cyc - e.acc;
        n_results++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                      input logic sub_v, input logic sat_v);
    exp_t e;
    int   t;
    a        = a_v;
    b        = b_v;
    sub      = sub_v;
    sat      = sat_v;
    in_valid = 1'b1;
    t        = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e     = model(a_v, b_v, sub_v, sat_v);
    e.acc = cyc;
    sb.push_back(e);
    n_expected++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk);
      #1 t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic rand_send();
    logic [W-1:0] v[2];
    for (int i = 0; i < 2; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i] = '0;
        1:       v[i] = W'(1);
        2:       v[i] = {1'b0, {(W-1){1'b1}}};
        3:       v[i] = {1'b1, {(W-1){1'b0}}};
        4:       v[i] = '1;
        default: v[i] = W'($urandom);
      endcase
    end
    send(v[0], v[1], 1'($urandom), 1'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, r0, t;
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_ovf", ovf, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Positive overflow, saturating then wrapping; latency checked on the first.
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    drain();
    check("latency", last_lat, S);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b0);
    send(16'h0007, 16'h0005, 1'b1, 1'b0);
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    drain();

    // Back-to-back accepts with the consumer always ready.
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(W'(i * 16'h1111), W'(16'h0F0F), 1'(i), 1'(i >> 1));
    check("throughput_cycles", cyc - c0, 8);
    drain();

    // Backpressure: consumer stalls for 3 cycles once the first result appears.
    r0 = n_results;
    fork
      begin
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h7000, 16'h2000, 1'b0, 1'b1);
        send(16'h8001, 16'h0002, 1'b1, 1'b1);
        send(16'h4000, 16'h4000, 1'b0, 1'b0);
      end
      begin
        t = 0;
        while (!out_valid && t < 50) begin
          @(posedge clk);
          #1 t++;
        end
        out_ready = 1'b0;
        check("bp_out_valid", out_valid, 1);
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_sum_hold", sum, sb[0].sum);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_results - r0, 4);

    // Asynchronous reset with two transactions in flight.
    send(16'h0100, 16'h0200, 1'b0, 1'b0);
    send(16'h0300, 16'h0400, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_in_ready", in_ready, 1);
    n_expected -= sb.size();
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_sum", sum, 0);

    // Randomised traffic with random consumer backpressure.
    rand_ready = 1'b1;
    repeat (300) rand_send();
    drain();

    // Overflow counter.
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    check("cnt_cleared", ovf_cnt, 0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b0);
    send(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
    drain();
    check("cnt_three", ovf_cnt, CNT_AFTER_3);
    out_ready = 1'b0;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk);
      #1 t++;
    end
    check("cnt_wait_valid", out_valid, 1);
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    check("cnt_clr_wins", ovf_cnt, 0);
    drain();

    check("result_count", n_results, n_expected);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
